// File: rtl/wbarb_pkg.sv
// Shared definitions for the N-master Wishbone arbiter: arbitration
// mode codes, the controller state type and small index helpers.
package wbarb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Widest master count the index helpers have to cover.
    localparam int MAX_NM = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Bits needed to hold a master index (never narrower than one bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Index of the set bit of a one-hot vector. ORing the indices keeps
    // this a plain OR tree rather than a priority chain; the result is
    // zero for an all-zero vector.
    function automatic int onehot_to_index(input logic [MAX_NM-1:0] oh);
        int idx;
        idx = 0;
        for (int k = 0; k < MAX_NM; k++) begin
            if (oh[k]) begin
                idx = idx | k;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wbarb_pick.sv
// Combinational requester picker for wbarbiter_n. Fixed mode grants the
// lowest requesting index; round-robin mode grants the first requester
// found scanning upward from the master after i_last, wrapping mod NM.
module wbarb_pick
    import wbarb_pkg::*;
#(
    parameter int NM       = 2,
    parameter int ARB_MODE = ARB_RR,
    parameter int IW       = idx_width(NM)
) (
    input  logic [NM-1:0] i_req,
    input  logic [IW-1:0] i_last,
    output logic [NM-1:0] o_grant,
    output logic          o_any
);

    int   idx;
    logic found;

    // Scan the requesters in priority order and grant the first one found.
    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NM; off++) begin
            if (ARB_MODE == ARB_FIXED) begin
                idx = off;
            end else begin
                idx = (int'(i_last) + 1 + off) % NM;
            end
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/wbarbiter_n.sv
// wbarbiter_n: N-master pipelined Wishbone arbiter. Grants one master the
// downstream bus with zero-latency grant out of idle, keeps it while that
// master holds cyc, counts outstanding requests and leaves one idle o_cyc
// cycle between owners.
// Optional feature: define WBARB_TIMEOUT_EN to add a watchdog that aborts
// an owner whose slave stops answering for TIMEOUT cycles.
module wbarbiter_n
    import wbarb_pkg::*;
#(
    parameter int NM       = 2,
    parameter int DW       = 32,
    parameter int AW       = 19,
    parameter int ARB_MODE = ARB_RR,
    parameter int LGOUT    = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NM-1:0]        i_cyc,
    input  logic [NM-1:0]        i_stb,
    input  logic [NM-1:0]        i_we,
    input  logic [NM*AW-1:0]     i_adr,
    input  logic [NM*DW-1:0]     i_dat,
    input  logic [NM*(DW/8)-1:0] i_sel,
    output logic [NM-1:0]        o_ack,
    output logic [NM-1:0]        o_stall,
    output logic [NM-1:0]        o_err,
    output logic [NM-1:0]        o_grant,
    output logic                 o_cyc,
    output logic                 o_stb,
    output logic                 o_we,
    output logic [AW-1:0]        o_adr,
    output logic [DW-1:0]        o_dat,
    output logic [DW/8-1:0]      o_sel,
    input  logic                 i_ack,
    input  logic                 i_stall,
    input  logic                 i_err
);

    localparam int IW = idx_width(NM);
    localparam int SW = DW / 8;

    arb_state_e       state_q, state_d;
    logic [NM-1:0]    grant_q, grant_d;
    logic [IW-1:0]    last_q, last_d;
    logic [LGOUT-1:0] count_q, count_d;

    logic [NM-1:0]    req;
    logic [NM-1:0]    blocked;
    logic [NM-1:0]    pick_grant;
    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic [NM-1:0]    cur_grant;
    logic [IW-1:0]    own_idx;
    logic             expire;
    logic             full;
    logic             accept;
    logic             ack_fwd;
    logic             err_fwd;

    // Masters aborted by the watchdog stay masked until they release cyc.
    assign req = i_cyc & ~blocked;

    wbarb_pick #(
        .NM       (NM),
        .ARB_MODE (ARB_MODE),
        .IW       (IW)
    ) u_pick (
        .i_req   (req),
        .i_last  (last_q),
        .o_grant (pick_grant),
        .o_any   (pick_any)
    );

    // Convert the one-hot picker result and the live owner into indices.
    always_comb begin
        logic [MAX_NM-1:0] pick_oh;
        logic [MAX_NM-1:0] own_oh;
        pick_oh          = '0;
        own_oh           = '0;
        pick_oh[NM-1:0]  = pick_grant;
        own_oh[NM-1:0]   = cur_grant;
        pick_idx         = IW'(onehot_to_index(pick_oh));
        own_idx          = IW'(onehot_to_index(own_oh));
    end

    // Ownership: grant out of idle, hold while the owner keeps cyc, release
    // on cyc drop or watchdog expiry. The release cycle is itself the idle
    // gap, so nobody else can be granted until the following cycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cur_grant = '0;
        if (!i_rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        cur_grant = pick_grant;
                        grant_d   = pick_grant;
                        last_d    = pick_idx;
                        state_d   = ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (expire || !(|(i_cyc & grant_q))) begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cur_grant = grant_q;
                    end
                end
                default: begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Downstream request path and upstream stall/ack/err routing.
    always_comb begin
        full    = (count_q == {LGOUT{1'b1}});
        o_grant = cur_grant;
        o_cyc   = |cur_grant;
        o_stb   = o_cyc & (|(i_stb & cur_grant)) & ~full;
        o_we    = i_we[own_idx];
        o_adr   = i_adr[int'(own_idx)*AW +: AW];
        o_dat   = i_dat[int'(own_idx)*DW +: DW];
        o_sel   = i_sel[int'(own_idx)*SW +: SW];
        o_stall = ~cur_grant | {NM{i_stall | full}};
        ack_fwd = o_cyc & i_ack & (count_q != '0);
        err_fwd = o_cyc & i_err & (count_q != '0);
        o_ack   = ack_fwd ? cur_grant : '0;
        o_err   = (err_fwd ? cur_grant : '0) | (expire ? grant_q : '0);
    end

    // Outstanding-request count: cleared whenever the bus is released or an
    // error ends the transaction, otherwise up on accept and down on ack.
    always_comb begin
        accept = o_stb & ~i_stall;
        if (!o_cyc || err_fwd) begin
            count_d = '0;
        end else begin
            count_d = count_q + LGOUT'(accept) - LGOUT'(ack_fwd);
        end
    end

    // Arbiter state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NM - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

`ifdef WBARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic [NM-1:0] blocked_q, blocked_d;

    assign blocked = blocked_q;
    assign expire  = !i_rst && (state_q == ST_OWNED) && (|(i_cyc & grant_q))
                     && (count_q != '0) && (tmr_q == TW'(TIMEOUT - 1));

    // Watchdog: count owned cycles with requests in flight, restart on any
    // response, and keep an aborted master masked until it drops cyc.
    always_comb begin
        tmr_d     = tmr_q;
        blocked_d = (blocked_q & i_cyc) | (expire ? grant_q : '0);
        if ((state_q != ST_OWNED) || !o_cyc || i_ack || i_err) begin
            tmr_d = '0;
        end else if (count_q != '0) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmr_q     <= '0;
            blocked_q <= '0;
        end else begin
            tmr_q     <= tmr_d;
            blocked_q <= blocked_d;
        end
    end
`else
    assign blocked = '0;
    assign expire  = 1'b0;
`endif

endmodule
